// File: rtl/basys_memory_pkg.sv
// Shared types and button indices for the Basys memory bank.
package basys_memory_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int NUM_BTN   = 5;
    localparam int BTN_WRITE = 0;
    localparam int BTN_READ  = 1;
    localparam int BTN_INC   = 2;
    localparam int BTN_CLEAR = 3;
    localparam int BTN_LOAD  = 4;

endpackage

// File: rtl/basys_memory_bank_btn_edge.sv
// Two-flop synchronizer per button followed by a rising-edge detector;
// each press produces exactly one single-cycle pulse.
module btn_edge #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] pulse
);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [WIDTH-1:0] prev_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pulse
            assign pulse[gi] = sync2_reg[gi] & ~prev_reg[gi];
        end
    endgenerate

endmodule

// File: rtl/basys_memory_bank.sv
// Button-driven word memory: write, read, pointer load/increment and a
// sequential clear that also runs after every reset.
module basys_memory_bank
    import basys_memory_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 16,
    parameter int AUTO_INC = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              sw,
    input  logic [4:0]               btn,
    output logic [15:0]              led,
    output logic [$clog2(DEPTH)-1:0] addr,
    output logic                     busy
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0]  mem [DEPTH];

    state_t             state_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [ADDR_W-1:0]  clr_idx_reg;
    logic [15:0]        led_reg;

    logic [NUM_BTN-1:0] pulse;
    logic               start_clear;
    logic               do_load;
    logic               do_write;
    logic               do_read;
    logic               do_inc;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [15:0]        rd_ext;
    logic [ADDR_W-1:0]  addr_inc;

    btn_edge #(.WIDTH(NUM_BTN)) u_btn_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn),
        .pulse (pulse)
    );

    // One action per cycle in IDLE, highest priority wins; pulses seen
    // during CLEAR simply fall on the floor.
    always_comb begin
        start_clear = 1'b0;
        do_load     = 1'b0;
        do_write    = 1'b0;
        do_read     = 1'b0;
        do_inc      = 1'b0;
        if (state_reg == IDLE) begin
            if (pulse[BTN_CLEAR])
                start_clear = 1'b1;
            else if (pulse[BTN_LOAD])
                do_load = 1'b1;
            else if (pulse[BTN_WRITE])
                do_write = 1'b1;
            else if (pulse[BTN_READ])
                do_read = 1'b1;
            else if (pulse[BTN_INC])
                do_inc = 1'b1;
        end
    end

    always_comb begin
        mem_we    = (state_reg == CLEAR) | do_write;
        mem_waddr = (state_reg == CLEAR) ? clr_idx_reg : addr_reg;
        mem_wdata = (state_reg == CLEAR) ? '0 : sw[DATA_W-1:0];
        rd_ext    = '0;
        rd_ext[DATA_W-1:0] = mem[addr_reg];
        addr_inc  = addr_reg + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= CLEAR;
            clr_idx_reg <= '0;
            addr_reg    <= '0;
            led_reg     <= '0;
        end else if (state_reg == CLEAR) begin
            clr_idx_reg <= clr_idx_reg + 1'b1;
            if (clr_idx_reg == LAST_IDX)
                state_reg <= IDLE;
        end else begin
            if (start_clear) begin
                state_reg   <= CLEAR;
                clr_idx_reg <= '0;
            end
            if (do_load)
                addr_reg <= sw[ADDR_W-1:0];
            else if (do_inc || ((AUTO_INC != 0) && (do_write || do_read)))
                addr_reg <= addr_inc;
            if (do_read)
                led_reg <= rd_ext;
        end
    end

    // No reset on the array so it maps onto distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    assign led  = led_reg;
    assign addr = addr_reg;
    assign busy = (state_reg == CLEAR);

endmodule

// File: doc/basys_memory_bank.md
BASYS_MEMORY_BANK -- requirements
Module: basys_memory_bank

Interface
REQ-001 Parameter DATA_W, default 16: stored word width; legal range 1..16.
REQ-002 Parameter DEPTH, default 16: word count; a power of two from 2 to 256; ADDR_W = log2(DEPTH).
REQ-003 Parameter AUTO_INC, default 0: when 1, the pointer advances after every write and every read.
REQ-004 CLK  input  1: single clock; all state changes on its rising edge.
REQ-005 RST_N  input  1: reset, asynchronous, active-low.
REQ-006 SW  input  16: SW[DATA_W-1:0] is write data; SW[ADDR_W-1:0] is pointer load value.
REQ-007 BTN  input  5: buttons, asynchronous to CLK. [0] up=write, [1] left=read, [2] right=increment pointer, [3] down=clear memory, [4] center=load pointer.
REQ-008 LED  output  16: read register, zero-extended above DATA_W.
REQ-009 ADDR  output  ADDR_W: current pointer.
REQ-010 BUSY  output  1: high while the clear sequence runs.

Function
REQ-011 Each BTN bit: two-flop synchronizer, then rising-edge detect producing a one-cycle pulse; a held button yields exactly one pulse.
REQ-012 Latency: BTN asserted before rising edge k -> action state visible after edge k+2 (three edges inclusive); releases create no pulse.
REQ-013 FSM states: IDLE, CLEAR; transitions IDLE->CLEAR on clear pulse, CLEAR->IDLE after writing index DEPTH-1.
REQ-014 CLEAR: one word per cycle, index 0..DEPTH-1, written with zero; BUSY=1 for exactly DEPTH cycles; LED and ADDR hold.
REQ-015 All button pulses arriving while in CLEAR are discarded, not queued.
REQ-016 In IDLE at most one action per cycle; priority clear > load > write > read > increment; lower-priority pulses in same cycle are discarded.
REQ-017 Write: mem[ADDR] <= SW[DATA_W-1:0].
REQ-018 Read: LED <= zero-extended mem[ADDR], registered; LED holds until next read, clear-entry leaves it unchanged.
REQ-019 Load: ADDR <= SW[ADDR_W-1:0].
REQ-020 Increment: ADDR <= ADDR+1 modulo DEPTH (DEPTH-1 wraps to 0).
REQ-021 AUTO_INC=1: write or read also increments ADDR in the same cycle; the read/write uses the pre-increment address.
REQ-022 Read of a word written in a previous cycle returns the new value; no same-cycle write+read (excluded by REQ-016).

Reset
REQ-023 RST_N low: ADDR=0, LED=0, synchronizer and edge flops=0, state=CLEAR, clear index=0, BUSY=1.
REQ-024 On RST_N release the clear sequence runs DEPTH cycles, leaving all memory zero before IDLE.
REQ-025 The memory array itself carries no reset; RST_N asserted mid-clear or mid-operation restarts the clear from index 0.

Structure
REQ-026 Package basys_memory_pkg holds the state enum (IDLE, CLEAR) and button-index constants (BTN_WRITE=0, BTN_READ=1, BTN_INC=2, BTN_CLEAR=3, BTN_LOAD=4).
REQ-027 Sub-module btn_edge, parametrised width, implements synchronizer plus rising-edge pulse; instantiated once for all 5 buttons.
REQ-028 Memory is a plain register array suitable for distributed RAM inference.

Verification (defaults unless stated)
REQ-029 Reset, then hold BTN=0 -> BUSY=1 for exactly 16 cycles after release; LED=0000, ADDR=0.
REQ-030 SW=5555, BTN=00001 for 3 cycles; release; BTN=00010 for 3 cycles -> LED=5555 after third edge; a held read gives no second action.
REQ-031 SW=0003, pulse load; SW=A5A5, pulse write; pulse increment ×13 -> ADDR wraps to 0; pulse load (SW=0003), read -> LED=A5A5.
REQ-032 Write 1234 to addr 2; pulse clear -> BUSY for 16 cycles; write/read pulses during BUSY ignored; read addr 2 -> LED=0000.
REQ-033 BTN=11111 in one cycle from IDLE -> only clear executes; memory zeroed, ADDR unchanged.
REQ-034 AUTO_INC=1, DATA_W=8, DEPTH=4: write SW=00AB, 00CD at ADDR 0,1 -> ADDR=2; load 0, read twice -> LED=00AB then 00CD; RST_N pulsed mid-clear -> clear restarts, BUSY 4 cycles after release.
